mdsa_shearsort_engine: RTL

//  Parametrised successor to the 8x32 multidimensional sorter. Holds an NxN matrix of DW-bit keys
//  and sorts it in place: snake-order shearsort (alternating row/column phases) or rows-only.

---
 rtl/mdsa_shearsort_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mdsa_shearsort_engine.sv
// NxN in-place matrix sorter: snake-order shearsort or rows-only odd-even transposition sort,
// sequenced by an internal FSM behind a start/busy/done handshake.
module mdsa_shearsort_engine #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              dir,
  input  logic [N*N*DW-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [N*N*DW-1:0] data_out
);

  localparam int LOG2N  = $clog2(N);
  localparam int P_FULL = 2 * LOG2N + 1;
  localparam int PW     = $clog2(P_FULL + 1);
  localparam logic [LOG2N-1:0] STEP_LAST       = LOG2N'(N - 1);
  localparam logic [PW-1:0]    PHASE_LAST_FULL = PW'(P_FULL - 1);

  typedef enum logic [1:0] {IDLE, SORT, FIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N*N*DW-1:0] mat;
  logic [N*N*DW-1:0] mat_nxt;
  logic [LOG2N-1:0]  step;
  logic [PW-1:0]     phase;
  logic              mode_q;
  logic              dir_q;
  logic              last_step;

  assign last_step = (step == STEP_LAST) &&
                     (phase == (mode_q ? {PW{1'b0}} : PHASE_LAST_FULL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SORT;
      SORT:    if (last_step) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // One odd-even transposition step over every row (even phase) or column (odd phase) at once;
  // the pairs touched in a single step never overlap, so all exchanges are independent.
  always_comb begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          desc;
    int            ia;
    int            ib;
    mat_nxt = mat;
    a       = '0;
    b       = '0;
    desc    = 1'b0;
    ia      = 0;
    ib      = 0;
    for (int ln = 0; ln < N; ln++) begin
      for (int k = 0; k < N - 1; k++) begin
        if (k[0] == step[0]) begin
          if (!phase[0]) begin
            ia   = (ln * N + k) * DW;
            ib   = ia + DW;
            desc = dir_q ^ (!mode_q && ln[0]);
          end else begin
            ia   = (k * N + ln) * DW;
            ib   = ((k + 1) * N + ln) * DW;
            desc = dir_q;
          end
          a = mat[ia +: DW];
          b = mat[ib +: DW];
          if (desc ? (a < b) : (a > b)) begin
            mat_nxt[ia +: DW] = b;
            mat_nxt[ib +: DW] = a;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mat    <= '0;
      step   <= '0;
      phase  <= '0;
      mode_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mat    <= data_in;
            mode_q <= mode;
            dir_q  <= dir;
            step   <= '0;
            phase  <= '0;
          end
        end
        SORT: begin
          mat <= mat_nxt;
          if (last_step) begin
            step  <= '0;
            phase <= '0;
          end else if (step == STEP_LAST) begin
            step  <= '0;
            phase <= phase + PW'(1);
          end else begin
            step <= step + LOG2N'(1);
          end
        end
        default: begin
          step  <= '0;
          phase <= '0;
        end
      endcase
    end
  end

  assign data_out = mat;

endmodule
